// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a single-entry holding register.
// The line is synchronized, then each bit is sampled at mid-bit by a down-counter.
// Completed bytes are presented on data with a level data_ready that the consumer
// clears with ack. overrun and frame_err are sticky flags, also cleared by ack.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to fall
// START     | half a bit time in, confirm start bit still low
// DATA      | sample 8 data bits LSB first, one bit time apart
// STOP      | sample stop bit; high commits the byte, low is a framing error
// WAIT_HIGH | after a framing error, hold off until the line returns high
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int CW       = $clog2(BIT_TIME) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_TIME / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;
  logic          commit;
  logic          ferr_evt;

  // Two-flop synchronizer; both flops reset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit sample outcomes: a high stop bit commits, a low one flags a framing error.
  always_comb begin
    commit   = (state == STOP) && (cnt == '0) && rx_s;
    ferr_evt = (state == STOP) && (cnt == '0) && !rx_s;
  end

  // Receive FSM, holding register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      data       <= 8'h00;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            cnt     <= FULL_LOAD;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift[bit_idx] <= rx_s;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A fresh byte always wins over an ack in the same cycle.
      if (commit) begin
        data       <= shift;
        data_ready <= 1'b1;
      end else if (ack) begin
        data_ready <= 1'b0;
      end

      // Overrun only when the old byte was neither consumed earlier nor acked now.
      if (commit && data_ready && !ack) begin
        overrun <= 1'b1;
      end else if (ack) begin
        overrun <= 1'b0;
      end

      if (ferr_evt) begin
        frame_err <= 1'b1;
      end else if (ack) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames, scoreboard-checked against a
// transaction-level model of what the consumer should observe.
module tb_uart_rx;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = CLK_FREQ >> 2;
  localparam int BT        = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       data_ready;
  logic       overrun;
  logic       frame_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .data_ready(data_ready),
    .ack(ack),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       o;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ev_cyc = 0;

  // consumer-visible model state
  logic       m_ready;
  logic       m_ovr;
  logic       m_fe;
  logic [7:0] m_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  // monitor: a new byte is presented when data_ready rises, data changes, or overrun rises
  logic [7:0] p_data = 8'h00;
  logic       p_rdy = 1'b0;
  logic       p_ovr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((data_ready && !p_rdy) || (data_ready && data != p_data) || (overrun && !p_ovr))) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_output actual=%0h expected=none", data);
      end else begin
        e = q.pop_front();
        chk("mon_data", data, e.d);
        chk("mon_overrun", overrun, e.o);
        chk("mon_frame_err", frame_err, e.f);
        ev_cyc = cyc;
      end
    end
    p_data = data;
    p_rdy  = data_ready;
    p_ovr  = overrun;
  end

  task automatic model_reset();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    m_last  = 8'h00;
    q.delete();
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    m_ovr   = m_ovr | m_ready;
    m_ready = 1'b1;
    m_last  = b;
    e.d = b;
    e.o = m_ovr;
    e.f = m_fe;
    q.push_back(e);
  endtask

  // all drive tasks start and end 1ns after a rising edge
  task automatic hold_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    start_cyc = cyc;
    hold_bit(1'b0, BT);
    for (int i = 0; i < 8; i++) hold_bit(b[i], BT);
    if (stop_low_bits > 0) hold_bit(1'b0, stop_low_bits * BT);
    hold_bit(1'b1, BT);
  endtask

  task automatic idle(input int n);
    hold_bit(1'b1, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // reset state
    chk("rst_data", data, 8'h00);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);

    // single byte, latency 2+2+36+1 (+/-1)
    expect_byte(8'h45);
    send_frame(8'h45, 0);
    wait_drain();
    checks++;
    if ((ev_cyc - start_cyc) < 40 || (ev_cyc - start_cyc) > 42) begin
      errors++;
      $display("FAIL latency actual=%0d expected=41", ev_cyc - start_cyc);
    end

    // ack drops data_ready the next cycle and keeps data, then a second byte
    pulse_ack();
    chk("ack_ready", data_ready, 1'b0);
    chk("ack_data_kept", data, 8'h45);
    expect_byte(8'hA5);
    send_frame(8'hA5, 0);
    wait_drain();

    // back-to-back without ack -> overrun, then ack clears all
    pulse_ack();
    expect_byte(8'h01);
    send_frame(8'h01, 0);
    expect_byte(8'hFF);
    send_frame(8'hFF, 0);
    wait_drain();
    pulse_ack();
    chk("ovr_ack_ready", data_ready, 1'b0);
    chk("ovr_ack_overrun", overrun, 1'b0);
    chk("ovr_ack_frame_err", frame_err, 1'b0);

    // one-cycle glitch is rejected
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(4 * BT);
    chk("glitch_ready", data_ready, 1'b0);
    chk("glitch_data", data, 8'hFF);

    // framing error, then a good byte with the sticky flag still set
    do_reset();
    idle(2);
    send_frame(8'h55, 3);
    idle(BT);
    m_fe = 1'b1;
    chk("ferr_flag", frame_err, 1'b1);
    chk("ferr_ready", data_ready, 1'b0);
    chk("ferr_data", data, 8'h00);
    expect_byte(8'h33);
    send_frame(8'h33, 0);
    wait_drain();
    pulse_ack();
    chk("ferr_ack_flag", frame_err, 1'b0);

    // reset during data bit 4 abandons the frame
    b = 8'hC3;
    hold_bit(1'b0, BT);
    for (int i = 0; i < 4; i++) hold_bit(b[i], BT);
    hold_bit(b[4], 2);
    rx = 1'b1;
    do_reset();
    idle(3 * BT);
    chk("abort_ready", data_ready, 1'b0);
    chk("abort_data", data, 8'h00);
    expect_byte(8'h3C);
    send_frame(8'h3C, 0);
    wait_drain();
    chk("abort_overrun", overrun, 1'b0);
    chk("abort_frame_err", frame_err, 1'b0);

    // randomized traffic with occasional acks and framing errors
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      if (m_ready && $urandom_range(0, 1) == 1) begin
        pulse_ack();
        chk("rnd_ack_ready", data_ready, 1'b0);
      end
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1);
        idle(2);
        m_fe = 1'b1;
        chk("rnd_frame_err", frame_err, 1'b1);
      end else begin
        if (m_ready && b == m_last) b = b ^ 8'h01;
        expect_byte(b);
        send_frame(b, 0);
        wait_drain();
      end
      idle($urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
